// File: rtl/alu_pkg.sv
// Shared definitions for the datapath ALU adder/subtractor: opcode encodings and
// default geometry of the pipelined lookahead adder.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ADDC = 2'b10,
        OP_SUBB = 2'b11
    } alu_op_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_GROUP = 4;
    localparam int DEF_GPS   = 2;

endpackage

// File: rtl/cla_group.sv
// GROUP-bit carry-lookahead block: sum bits, carry out, and group propagate/generate
// so that neighbouring groups can be chained one level up.
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             ci,
    output logic [GROUP-1:0] s,
    output logic             co,
    output logic             p,
    output logic             g
);

    logic [GROUP-1:0] w_p;
    logic [GROUP-1:0] w_g;
    logic [GROUP:0]   w_c;
    logic             w_grp_g;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Each carry is a flat sum of products over bit P/G, so no bit waits on its neighbour.
    always_comb begin
        logic [GROUP:0] v_c;
        logic           v_t;
        v_c = '0;
        v_t = 1'b0;
        for (int i = 0; i <= GROUP; i++) begin
            v_t = ci;
            for (int j = 0; j < i; j++) v_t = v_t & w_p[j];
            v_c[i] = v_t;
            for (int j = 0; j < i; j++) begin
                v_t = w_g[j];
                for (int k = j + 1; k < i; k++) v_t = v_t & w_p[k];
                v_c[i] = v_c[i] | v_t;
            end
        end
        w_c = v_c;
    end

    always_comb begin
        logic v_t;
        v_t     = 1'b0;
        w_grp_g = 1'b0;
        for (int j = 0; j < GROUP; j++) begin
            v_t = w_g[j];
            for (int k = j + 1; k < GROUP; k++) v_t = v_t & w_p[k];
            w_grp_g = w_grp_g | v_t;
        end
    end

    assign s  = w_p ^ w_c[GROUP-1:0];
    assign co = w_c[GROUP];
    assign p  = &w_p;
    assign g  = w_grp_g;

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined lookahead adder/subtractor with ALU flags; each stage resolves GPS groups
// and the whole pipe advances or stalls together under a single valid/ready handshake.
module pipelined_cla_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GROUP = DEF_GROUP,
    parameter int GPS   = DEF_GPS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int SW     = GROUP * GPS;
    localparam int STAGES = WIDTH / SW;

    if (WIDTH % SW != 0) begin : g_bad_geometry
        $error("pipelined_cla_addsub: WIDTH must be a multiple of GROUP*GPS");
    end

    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;
    logic             w_advance;
    logic             r_ovf;
    logic             r_zero;
    logic             r_neg;

    always_comb begin
        w_b_eff = b;
        w_c0    = 1'b0;
        case (alu_op_e'(op))
            OP_ADD:  begin w_b_eff = b;  w_c0 = 1'b0; end
            OP_SUB:  begin w_b_eff = ~b; w_c0 = 1'b1; end
            OP_ADDC: begin w_b_eff = b;  w_c0 = cin;  end
            OP_SUBB: begin w_b_eff = ~b; w_c0 = cin;  end
            default: ;
        endcase
    end

    assign w_advance = ~out_valid | out_ready;
    assign in_ready  = w_advance;

    genvar gi, gj;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            // Operand slices still to be added: this stage's slice plus everything above it.
            localparam int UW = WIDTH - gi * SW;

            logic [UW-1:0]        w_a_in;
            logic [UW-1:0]        w_b_in;
            logic                 w_v_in;
            logic                 w_c_in;
            logic [SW-1:0]        w_slice;
            logic [(gi+1)*SW-1:0] w_s_out;
            logic [GPS:0]         w_gc;
            logic [GPS-1:0]       w_gp;
            logic [GPS-1:0]       w_gg;
            logic [GPS-1:0]       w_co_unused;
            logic                 r_valid;
            logic                 r_c;
            logic [(gi+1)*SW-1:0] r_s;

            if (gi == 0) begin : g_first
                assign w_a_in  = a;
                assign w_b_in  = w_b_eff;
                assign w_v_in  = in_valid;
                assign w_c_in  = w_c0;
                assign w_s_out = w_slice;
            end else begin : g_next
                assign w_a_in  = g_stage[gi-1].g_fwd.r_a;
                assign w_b_in  = g_stage[gi-1].g_fwd.r_b;
                assign w_v_in  = g_stage[gi-1].r_valid;
                assign w_c_in  = g_stage[gi-1].r_c;
                assign w_s_out = {w_slice, g_stage[gi-1].r_s};
            end

            // Group carries come from the P/G chain; each group's own co is redundant here.
            assign w_gc[0] = w_c_in;
            for (gj = 0; gj < GPS; gj++) begin : g_group
                cla_group #(
                    .GROUP (GROUP)
                ) u_group (
                    .a  (w_a_in[gj*GROUP +: GROUP]),
                    .b  (w_b_in[gj*GROUP +: GROUP]),
                    .ci (w_gc[gj]),
                    .s  (w_slice[gj*GROUP +: GROUP]),
                    .co (w_co_unused[gj]),
                    .p  (w_gp[gj]),
                    .g  (w_gg[gj])
                );
                assign w_gc[gj+1] = w_gg[gj] | (w_gp[gj] & w_gc[gj]);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_c     <= 1'b0;
                    r_s     <= '0;
                end else if (w_advance) begin
                    r_valid <= w_v_in;
                    r_c     <= w_gc[GPS];
                    r_s     <= w_s_out;
                end
            end

            if (gi < STAGES - 1) begin : g_fwd
                logic [UW-SW-1:0] r_a;
                logic [UW-SW-1:0] r_b;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_a <= '0;
                        r_b <= '0;
                    end else if (w_advance) begin
                        r_a <= w_a_in[UW-1:SW];
                        r_b <= w_b_in[UW-1:SW];
                    end
                end
            end
        end
    endgenerate

    logic [WIDTH-1:0] w_last_s;
    logic             w_last_a_msb;
    logic             w_last_b_msb;

    assign w_last_s     = g_stage[STAGES-1].w_s_out;
    assign w_last_a_msb = g_stage[STAGES-1].w_a_in[SW-1];
    assign w_last_b_msb = g_stage[STAGES-1].w_b_in[SW-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (w_advance) begin
            r_ovf  <= (w_last_a_msb ~^ w_last_b_msb) & (w_last_s[WIDTH-1] ^ w_last_a_msb);
            r_zero <= ~|w_last_s;
            r_neg  <= w_last_s[WIDTH-1];
        end
    end

    assign out_valid = g_stage[STAGES-1].r_valid;
    assign sum       = g_stage[STAGES-1].r_s;
    assign cout      = g_stage[STAGES-1].r_c;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
    assign neg       = r_neg;

endmodule

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the MIPS datapath ALU.
- Successor to the fixed 4-bit lookahead adder: generalised to WIDTH bits built from GROUP-bit lookahead groups.
- Registered every GPS groups. Adds subtract/carry-in modes, ALU flags and a valid/ready handshake so it can stall with the EX stage.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of GROUP*GPS.
- GROUP, 4, bits per carry-lookahead group.
- GPS, 2, groups resolved per pipeline stage; STAGES = WIDTH/(GROUP*GPS), default 4.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  2  00 ADD, 01 SUB, 10 ADDC (uses cin), 11 SUBB (borrow = ~cin).
- cin  in  1  carry in, used only for ADDC/SUBB.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB; for SUB/SUBB, 1 means no borrow.
- ovf  out  1  signed overflow.
- zero  out  1  sum == 0.
- neg  out  1  sum[WIDTH-1].

Behaviour:
- Reset: async on rst_n low. All stage valid bits clear, out_valid=0, sum=0, cout=0, ovf=0, zero=0, neg=0. in_ready becomes 1 the first cycle after release.
- Operand prep (input stage, combinational):
  - b_eff = b for ADD/ADDC, ~b for SUB/SUBB.
  - c0 = 0 for ADD, 1 for SUB, cin for ADDC and SUBB.
  - For SUBB, c0 = cin means A - B - ~cin.
- Stage k (k = 0..STAGES-1):
  - Computes bits [k*GROUP*GPS +: GROUP*GPS] from the carry registered by stage k-1 (c0 for k=0).
  - Uses per-group P/G lookahead; ripple-free inside a group.
  - Registers the partial sum, the carry out, and the still-unused upper a/b_eff slices.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES.
- Handshake:
  - advance = ~out_valid | out_ready, global for the whole pipeline.
  - in_ready = advance.
  - Beat accepted when in_valid & in_ready.
  - All stages shift together only when advance=1; otherwise every stage holds.
  - Bubbles are not collapsed.
  - Throughput is 1 beat/cycle while out_ready=1.
- Output stability: while out_valid=1 and out_ready=0, sum/cout/ovf/zero/neg and out_valid hold constant.
- Flags are computed in the last stage from the full result:
  - ovf = (a[MSB] ~^ b_eff[MSB]) & (sum[MSB] ^ a[MSB]); the operand MSBs are carried down the pipe.
  - zero, neg as defined in Ports.
- Data-path values when the corresponding valid bit is 0 are don't-care, except the output registers, which reset to 0.
- Simultaneous events:
  - Input accept and output drain in the same cycle are legal; occupancy is unchanged.
  - in_valid=0 while advance=1 inserts a bubble.
- Reset mid-operation: all in-flight beats are discarded and no partial result is emitted.
- Parameter violation (WIDTH % (GROUP*GPS) != 0) is an elaboration error via generate-time check.

Decomposition:
- Shared package alu_pkg:
  - op encodings OP_ADD/OP_SUB/OP_ADDC/OP_SUBB.
  - default WIDTH/GROUP constants.
- Sub-module cla_group:
  - Parametrised GROUP-bit lookahead: inputs a, b, ci; outputs s, co, group P, group G.
  - Instantiated GPS times per stage; group P/G chained within a stage to form the stage carry.
- Pipeline registers and handshake live in the top.

Test Plan:
- ADD, WIDTH=32: a=0x0000_FFFF, b=0x0000_0001, single beat, out_ready=1 -> after 4 cycles sum=0x0001_0000, cout=0, ovf=0, zero=0, neg=0.
- SUB overflow: a=0x8000_0000, b=0x0000_0001 -> sum=0x7FFF_FFFF, ovf=1, cout=1, neg=0. SUB with a=5, b=5 -> sum=0, zero=1, cout=1.
- ADDC/SUBB: a=0xFFFF_FFFF, b=0, op=ADDC, cin=1 -> sum=0, cout=1, zero=1. a=10, b=3, op=SUBB, cin=0 -> sum=6.
- Backpressure: stream 6 back-to-back beats (a=i, b=i) with out_ready low for cycles 5-8 -> in_ready=0 during the stall, outputs hold 2*i unchanged, all 6 results emerge in order, none lost or duplicated.
- Bubbles: in_valid pattern 1,0,1,1,0 -> out_valid pattern identical, delayed by exactly 4 cycles.
- Reset mid-stream: 3 beats in flight, rst_n pulsed low for 1 cycle -> out_valid=0 and all outputs 0 immediately; no stale beats emitted afterwards. Repeat with GROUP=4, GPS=1, WIDTH=16 (STAGES=4) and WIDTH=8, GPS=2 (STAGES=1).
